raster_dispatch: RTL and testbench



---
 rtl/raster_dispatch_if.sv | 35 +++
 rtl/raster_dispatch.sv | 227 ++++++++++++++++++++++
 tb/tb_raster_dispatch.sv | 379 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/raster_dispatch_if.sv
// Triangle intake and rasterizer launch bus of raster_dispatch.
// slave = the dispatcher; master = geometry source plus rasterizer side.
interface raster_dispatch_if;
   logic        tri_valid;
   logic        tri_ready;
   logic [63:0] tri_v1;
   logic [63:0] tri_v2;
   logic [63:0] tri_v3;
   logic [31:0] tri_iz1;
   logic [31:0] tri_iz2;
   logic [31:0] tri_iz3;

   logic        rast_start;
   logic [63:0] rast_v1;
   logic [63:0] rast_v2;
   logic [63:0] rast_v3;
   logic [31:0] rast_iz1;
   logic [31:0] rast_iz2;
   logic [31:0] rast_iz3;
   logic        rast_done;

   modport slave (
      input  tri_valid, tri_v1, tri_v2, tri_v3, tri_iz1, tri_iz2, tri_iz3,
      output tri_ready,
      output rast_start, rast_v1, rast_v2, rast_v3, rast_iz1, rast_iz2, rast_iz3,
      input  rast_done
   );

   modport master (
      output tri_valid, tri_v1, tri_v2, tri_v3, tri_iz1, tri_iz2, tri_iz3,
      input  tri_ready,
      input  rast_start, rast_v1, rast_v2, rast_v3, rast_iz1, rast_iz2, rast_iz3,
      output rast_done
   );
endinterface

// File: rtl/raster_dispatch.sv
// Frame controller: clears the z-buffer, queues triangles and launches them into the rasterizer.
// Optional depth-range culling of queued triangles is built with RASTER_DISPATCH_CULL_EN.
module raster_dispatch #(
   parameter int SCREEN_WIDTH  = 320,
   parameter int SCREEN_HEIGHT = 240,
   parameter int FIFO_DEPTH    = 4
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic                   i_frame_start,
   input  logic                   i_frame_end,
   raster_dispatch_if.slave       bus,
   output logic                   o_clr_we,
   output logic [16:0]            o_clr_addr,
   output logic [31:0]            o_clr_data,
   output logic                   o_clr_active,
   output logic                   o_busy,
   output logic                   o_frame_done,
   output logic [15:0]            o_cull_count
);

   localparam int          CLR_WORDS = SCREEN_WIDTH * SCREEN_HEIGHT;
   localparam logic [16:0] CLR_LAST  = 17'(CLR_WORDS - 1);
   localparam int          PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [PTR_W:0] CNT_FULL = (PTR_W + 1)'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_RUN,
      S_ACK,
      S_WAIT_DONE
   } state_t;

   typedef struct packed {
      logic [63:0] v1;
      logic [63:0] v2;
      logic [63:0] v3;
      logic [31:0] iz1;
      logic [31:0] iz2;
      logic [31:0] iz3;
   } tri_t;

   state_t         state_q, state_d;
   logic [16:0]    clr_addr_q, clr_addr_d;
   logic           end_q, end_d;
   logic           start_q, start_d;
   logic           fdone_q, fdone_d;
   tri_t           rast_q, rast_d;

   tri_t           fifo_q [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [PTR_W:0] cnt_q;

   tri_t           in_tri;
   tri_t           head;
   logic           tri_ready;
   logic           push;
   logic           pop;
   logic           head_cull;

   assign in_tri    = {bus.tri_v1, bus.tri_v2, bus.tri_v3,
                       bus.tri_iz1, bus.tri_iz2, bus.tri_iz3};
   assign head      = fifo_q[rd_ptr_q];
   assign tri_ready = (cnt_q != CNT_FULL) && !end_q && (state_q != S_IDLE);
   assign push      = bus.tri_valid && tri_ready;

`ifdef RASTER_DISPATCH_CULL_EN
   localparam logic signed [31:0] IZ_MAX = 32'sd327680;

   logic [15:0] cull_q, cull_d;

   function automatic logic iz_out(input logic signed [31:0] iz);
      return (iz <= 32'sd0) || (iz > IZ_MAX);
   endfunction

   function automatic logic cull_hit(input tri_t t);
      return iz_out(t.iz1) && iz_out(t.iz2) && iz_out(t.iz3);
   endfunction

   assign head_cull = cull_hit(head);

   always_comb begin
      cull_d = cull_q;
      if (state_q == S_IDLE && i_frame_start) begin
         cull_d = '0;
      end else if (state_q == S_RUN && cnt_q != '0 && head_cull && cull_q != 16'hFFFF) begin
         cull_d = cull_q + 16'd1;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cull_q <= '0;
      end else begin
         cull_q <= cull_d;
      end
   end

   assign o_cull_count = cull_q;
`else
   assign head_cull    = 1'b0;
   assign o_cull_count = '0;
`endif

   always_comb begin
      state_d    = state_q;
      clr_addr_d = clr_addr_q;
      end_d      = end_q;
      start_d    = 1'b0;
      fdone_d    = 1'b0;
      rast_d     = rast_q;
      pop        = 1'b0;

      if (state_q != S_IDLE && i_frame_end) begin
         end_d = 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            if (i_frame_start) begin
               state_d    = S_CLEAR;
               clr_addr_d = '0;
               end_d      = 1'b0;
            end
         end
         S_CLEAR: begin
            if (clr_addr_q == CLR_LAST) begin
               state_d = S_RUN;
            end else begin
               clr_addr_d = clr_addr_q + 17'd1;
            end
         end
         S_RUN: begin
            // A culled head is dropped without waiting on the rasterizer.
            if (cnt_q != '0) begin
               if (head_cull) begin
                  pop = 1'b1;
               end else if (bus.rast_done) begin
                  pop     = 1'b1;
                  rast_d  = head;
                  start_d = 1'b1;
                  state_d = S_ACK;
               end
            end else if (end_q && bus.rast_done) begin
               fdone_d = 1'b1;
               state_d = S_IDLE;
            end
         end
         S_ACK: begin
            if (!bus.rast_done) begin
               state_d = S_WAIT_DONE;
            end
         end
         S_WAIT_DONE: begin
            if (bus.rast_done) begin
               state_d = S_RUN;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= S_IDLE;
         clr_addr_q <= '0;
         end_q      <= 1'b0;
         start_q    <= 1'b0;
         fdone_q    <= 1'b0;
         rast_q     <= '0;
      end else begin
         state_q    <= state_d;
         clr_addr_q <= clr_addr_d;
         end_q      <= end_d;
         start_q    <= start_d;
         fdone_q    <= fdone_d;
         rast_q     <= rast_d;
      end
   end

   // Queue bookkeeping: wrapping pointers, occupancy count decides full/empty.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   cnt_q <= cnt_q + (PTR_W + 1)'(1);
            2'b01:   cnt_q <= cnt_q - (PTR_W + 1)'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (push) begin
         fifo_q[wr_ptr_q] <= in_tri;
      end
   end

   assign bus.tri_ready  = tri_ready;
   assign bus.rast_start = start_q;
   assign bus.rast_v1    = rast_q.v1;
   assign bus.rast_v2    = rast_q.v2;
   assign bus.rast_v3    = rast_q.v3;
   assign bus.rast_iz1   = rast_q.iz1;
   assign bus.rast_iz2   = rast_q.iz2;
   assign bus.rast_iz3   = rast_q.iz3;

   assign o_clr_we     = (state_q == S_CLEAR);
   assign o_clr_addr   = clr_addr_q;
   assign o_clr_data   = '0;
   assign o_clr_active = (state_q == S_CLEAR);
   assign o_busy       = (state_q != S_IDLE);
   assign o_frame_done = fdone_q;

endmodule

// File: tb/tb_raster_dispatch.sv
// Randomized bench for raster_dispatch against a queue-based frame model.
// Reduced screen size keeps each clear short; culling expectations follow RASTER_DISPATCH_CULL_EN.
module tb_raster_dispatch;
   localparam int W     = 8;
   localparam int H     = 4;
   localparam int DEPTH = 4;
   localparam int CLR_N = W * H;

   typedef logic [287:0] rec_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        frame_start;
   logic        frame_end;
   logic        clr_we;
   logic [16:0] clr_addr;
   logic [31:0] clr_data;
   logic        clr_active;
   logic        busy;
   logic        frame_done;
   logic [15:0] cull_count;

   raster_dispatch_if bus ();

   raster_dispatch #(
      .SCREEN_WIDTH (W),
      .SCREEN_HEIGHT(H),
      .FIFO_DEPTH   (DEPTH)
   ) dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_frame_start(frame_start),
      .i_frame_end  (frame_end),
      .bus          (bus),
      .o_clr_we     (clr_we),
      .o_clr_addr   (clr_addr),
      .o_clr_data   (clr_data),
      .o_clr_active (clr_active),
      .o_busy       (busy),
      .o_frame_done (frame_done),
      .o_cull_count (cull_count)
   );

   always #5 clk = ~clk;

   int     n_cmp = 0;
   int     n_err = 0;
   longint cyc = 0;
   rec_t   exp_q[$];
   rec_t   got_q[$];
   int     exp_cull;
   int     clr_words = 0;
   int     clr_bad = 0;
   int     fd_pulses = 0;
   longint last_clr_cyc = 0;
   longint fd_cyc = 0;
   logic   prev_we = 1'b0;
   logic [16:0] prev_addr = '0;
   bit     stall = 1'b1;
   int     rast_delay = 0;
   int     rcnt = 0;

   task automatic chk(input string tag, input logic [287:0] got, input logic [287:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic rec_t mk(input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                               input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
      return {a, b, c, x, y, z};
   endfunction

   // Depth window is (0, 5.0] in 16.16.
   function automatic bit out_of_range(input int z);
      return (z <= 0) || (z > 5 * 65536);
   endfunction

   function automatic bit model_culled(input rec_t t);
`ifdef RASTER_DISPATCH_CULL_EN
      return out_of_range($signed(t[95:64])) && out_of_range($signed(t[63:32])) &&
             out_of_range($signed(t[31:0]));
`else
      return (t[0] !== t[0]);
`endif
   endfunction

   function automatic logic [31:0] rand_iz();
      case ($urandom_range(0, 4))
         0:       return 32'd0;
         1:       return 32'(-int'($urandom_range(1, 1000)));
         2:       return 32'(327681 + $urandom_range(0, 100000));
         3:       return 32'd327680;
         default: return 32'($urandom_range(1, 327680));
      endcase
   endfunction

   function automatic rec_t rand_tri(input bit good);
      rec_t t;
      t = mk({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, 32'd0, 32'd0, 32'd0);
      if (good) begin
         t[95:0] = {32'($urandom_range(1, 327680)), 32'($urandom_range(1, 327680)),
                    32'($urandom_range(1, 327680))};
      end else begin
         t[95:0] = {rand_iz(), rand_iz(), rand_iz()};
      end
      return t;
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (bus.rast_start === 1'b1) begin
         got_q.push_back({bus.rast_v1, bus.rast_v2, bus.rast_v3,
                          bus.rast_iz1, bus.rast_iz2, bus.rast_iz3});
      end
      if (frame_done === 1'b1) begin
         fd_pulses++;
         fd_cyc = cyc;
      end
      if (clr_we === 1'b1) begin
         if (clr_addr !== (prev_we ? 17'(prev_addr + 17'd1) : 17'd0)) clr_bad++;
         if (clr_data !== 32'd0) clr_bad++;
         clr_words++;
         last_clr_cyc = cyc;
      end
      prev_we   = clr_we;
      prev_addr = clr_addr;
   end

   // Rasterizer: drops done the cycle it sees start, raises it rast_delay+1 cycles later.
   always @(negedge clk) begin
      if (stall) begin
         bus.rast_done = 1'b0;
         rcnt = 0;
      end else if (bus.rast_start === 1'b1) begin
         bus.rast_done = 1'b0;
         rcnt = rast_delay;
      end else if (bus.rast_done !== 1'b1) begin
         if (rcnt == 0) bus.rast_done = 1'b1;
         else rcnt--;
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic set_tri(input rec_t t);
      {bus.tri_v1, bus.tri_v2, bus.tri_v3, bus.tri_iz1, bus.tri_iz2, bus.tri_iz3} = t;
   endtask

   task automatic note_accept(input rec_t t);
      if (model_culled(t)) exp_cull++;
      else exp_q.push_back(t);
   endtask

   task automatic push_tri(input rec_t t);
      int waited = 0;
      set_tri(t);
      bus.tri_valid = 1'b1;
      while (bus.tri_ready !== 1'b1 && waited < 300) begin
         tick();
         waited++;
      end
      if (bus.tri_ready !== 1'b1) chk("push_ready_timeout", bus.tri_ready, 1);
      else note_accept(t);
      tick();
      bus.tri_valid = 1'b0;
   endtask

   task automatic start_frame();
      exp_q.delete();
      exp_cull = 0;
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
   endtask

   task automatic end_frame();
      frame_end = 1'b1;
      tick();
      frame_end = 1'b0;
   endtask

   task automatic wait_clear(input string tag);
      for (int i = 0; i < CLR_N + 20 && clr_active === 1'b1; i++) tick();
      chk(tag, clr_active, 0);
   endtask

   task automatic wait_frame_done(input int budget, input string tag);
      for (int i = 0; i < budget && frame_done !== 1'b1; i++) tick();
      chk(tag, frame_done, 1);
      repeat (3) tick();
   endtask

   task automatic check_launches(input int base, input string tag);
      chk({tag, "_n"}, got_q.size() - base, exp_q.size());
      for (int i = 0; i < exp_q.size() && base + i < got_q.size(); i++) begin
         chk($sformatf("%s_op%0d", tag, i), got_q[base + i], exp_q[i]);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int     base, w0, b0, f0, k;
      longint start_cyc;
      rec_t   t, bp[6];

      rst_n = 1'b0;
      frame_start = 1'b0;
      frame_end = 1'b0;
      bus.tri_valid = 1'b0;
      set_tri('0);
      repeat (3) tick();

      chk("rst_busy", busy, 0);
      chk("rst_ready", bus.tri_ready, 0);
      chk("rst_clr_we", clr_we, 0);
      chk("rst_start", bus.rast_start, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_cull", cull_count, 0);
      chk("rst_rast_v1", bus.rast_v1, 0);
      chk("rst_rast_iz3", bus.rast_iz3, 0);

      rst_n = 1'b1;
      stall = 1'b0;
      repeat (2) tick();

      // Clear sweep followed by a single triangle
      base = got_q.size(); w0 = clr_words; b0 = clr_bad; f0 = fd_pulses;
      start_frame();
      chk("clr_active", clr_active, 1);
      chk("ready_in_clear", bus.tri_ready, 1);
      wait_clear("clr_finish");
      chk("clr_words", clr_words - w0, CLR_N);
      chk("clr_bad", clr_bad - b0, 0);
      chk("run_busy", busy, 1);
      rast_delay = 20;
      t = mk({32'd256, 32'd256}, {32'd2560, 32'd256}, {32'd256, 32'd2560},
             32'd65536, 32'd65536, 32'd65536);
      set_tri(t);
      bus.tri_valid = 1'b1;
      chk("single_ready", bus.tri_ready, 1);
      note_accept(t);
      tick();
      bus.tri_valid = 1'b0;
      chk("lat_start_early", bus.rast_start, 0);
      tick();
      start_cyc = cyc;
      chk("lat_start", bus.rast_start, 1);
      chk("lat_ops", {bus.rast_v1, bus.rast_v2, bus.rast_v3, bus.rast_iz1, bus.rast_iz2, bus.rast_iz3}, t);
      tick();
      chk("start_pulse_width", bus.rast_start, 0);
      chk("ops_held", {bus.rast_v1, bus.rast_v2, bus.rast_v3, bus.rast_iz1, bus.rast_iz2, bus.rast_iz3}, t);
      end_frame();
      wait_frame_done(100, "single_fd");
      chk("single_fd_cycle", fd_cyc - start_cyc, 23);
      chk("single_fd_pulses", fd_pulses - f0, 1);
      chk("single_idle", busy, 0);
      check_launches(base, "single");

      // Backpressure with the rasterizer stalled
      base = got_q.size(); f0 = fd_pulses;
      rast_delay = 2;
      stall = 1'b1;
      for (int i = 0; i < 6; i++) bp[i] = rand_tri(1'b1);
      start_frame();
      k = 0;
      for (int c = 0; c < 10; c++) begin
         if (k < 6) begin
            set_tri(bp[k]);
            bus.tri_valid = 1'b1;
            if (bus.tri_ready === 1'b1) begin
               note_accept(bp[k]);
               k++;
            end
         end
         tick();
      end
      chk("bp_accepted", k, 4);
      chk("bp_ready_low", bus.tri_ready, 0);
      bus.tri_valid = 1'b0;
      stall = 1'b0;
      for (int i = 4; i < 6; i++) push_tri(bp[i]);
      end_frame();
      wait_frame_done(400, "bp_fd");
      chk("bp_fd_pulses", fd_pulses - f0, 1);
      check_launches(base, "bp");

      // Empty frame: end arrives during the clear
      base = got_q.size(); f0 = fd_pulses;
      start_frame();
      repeat (3) tick();
      chk("empty_in_clear", clr_active, 1);
      end_frame();
      chk("empty_ready_after_end", bus.tri_ready, 0);
      wait_frame_done(CLR_N + 20, "empty_fd");
      chk("empty_fd_gap", fd_cyc - last_clr_cyc, 2);
      chk("empty_fd_pulses", fd_pulses - f0, 1);
      check_launches(base, "empty");

      // Culling: out-of-range triangle between two valid ones
      base = got_q.size();
      rast_delay = 1;
      start_frame();
      wait_clear("cull_clear");
      push_tri(rand_tri(1'b1));
      push_tri(mk({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
                  32'd0, 32'd0, 32'd400000));
      push_tri(rand_tri(1'b1));
      end_frame();
      wait_frame_done(200, "cull_fd");
`ifdef RASTER_DISPATCH_CULL_EN
      chk("cull_launches", got_q.size() - base, 2);
      chk("cull_count", cull_count, 1);
`else
      chk("cull_launches", got_q.size() - base, 3);
      chk("cull_count", cull_count, 0);
`endif
      check_launches(base, "cull");

      // Reset asserted while waiting on the rasterizer
      rast_delay = 40;
      start_frame();
      for (int i = 0; i < 3; i++) push_tri(rand_tri(1'b1));
      for (int i = 0; i < CLR_N + 20 && bus.rast_start !== 1'b1; i++) tick();
      chk("mid_launch", bus.rast_start, 1);
      repeat (2) tick();
      chk("mid_busy_before", busy, 1);
      rst_n = 1'b0;
      #1;
      chk("mid_busy", busy, 0);
      chk("mid_clr_we", clr_we, 0);
      chk("mid_ready", bus.tri_ready, 0);
      chk("mid_rast_v1", bus.rast_v1, 0);
      tick();
      rst_n = 1'b1;
      stall = 1'b1;
      tick();
      stall = 1'b0;
      repeat (2) tick();
      base = got_q.size(); f0 = fd_pulses;
      rast_delay = 3;
      start_frame();
      wait_clear("post_rst_clear");
      push_tri(rand_tri(1'b1));
      end_frame();
      wait_frame_done(200, "post_rst_fd");
      chk("post_rst_fd_pulses", fd_pulses - f0, 1);
      check_launches(base, "post_rst");

      // Randomized frames
      for (int f = 0; f < 4; f++) begin
         base = got_q.size(); f0 = fd_pulses;
         rast_delay = $urandom_range(0, 5);
         start_frame();
         for (int i = 0; i < int'($urandom_range(3, 9)); i++) begin
            repeat ($urandom_range(0, 2)) tick();
            push_tri(rand_tri(1'b0));
         end
         end_frame();
         wait_frame_done(600, $sformatf("rnd%0d_fd", f));
         chk($sformatf("rnd%0d_fd_pulses", f), fd_pulses - f0, 1);
         chk($sformatf("rnd%0d_cull", f), cull_count, exp_cull);
         check_launches(base, $sformatf("rnd%0d", f));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
